// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM address, field split,
// next-PC select and start/run/halt sequencer with cycle count.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       InstrData,
  input  logic             Branch,
  input  logic             BrTaken,
  input  logic             Halt,
  output logic [PC_W-1:0]  InstrAddr,
  output logic             TypeBit,
  output logic [3:0]       OP,
  output logic [3:0]       RegSel,
  output logic             Valid,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  br_off;
  logic [CNT_W-1:0] cnt_inc;

  assign br_off  = PC_W'($signed(InstrData[7:0]));
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  assign InstrAddr  = pc_q;
  assign TypeBit    = InstrData[8];
  assign OP         = InstrData[7:4];
  assign RegSel     = InstrData[3:0];
  assign Valid      = (state_q == S_RUN);
  assign Done       = (state_q == S_HALTED);
  assign CycleCount = cnt_q;

  // Next state, PC and cycle count; Start re-arms from anywhere
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (Start) begin
      state_d = S_ARMED;
      pc_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (1'b1)
        state_q == S_IDLE:   state_d = S_IDLE;
        state_q == S_ARMED:  state_d = S_RUN;
        state_q == S_RUN: begin
          cnt_d = cnt_inc;
          if (Halt) begin
            state_d = S_HALTED;
          end else if (Branch && BrTaken) begin
            pc_d = pc_q + br_off;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        state_q == S_HALTED: state_d = S_HALTED;
        default:             state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the
// main run/branch/halt flow plus hand sequences for corners.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Branch, BrTaken, Halt;
  logic [8:0] InstrData;
  logic [9:0] InstrAddr, sat_addr;
  logic       TypeBit, Valid, Done;
  logic       sat_tb, sat_v, sat_d;
  logic [3:0] OP, RegSel, sat_op, sat_rs;
  logic [15:0] CycleCount;
  logic [2:0]  sat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .InstrData(InstrData), .Branch(Branch),
    .BrTaken(BrTaken), .Halt(Halt),
    .InstrAddr(InstrAddr), .TypeBit(TypeBit),
    .OP(OP), .RegSel(RegSel), .Valid(Valid),
    .Done(Done), .CycleCount(CycleCount)
  );

  fetch_unit #(.PC_W(10), .CNT_W(3)) u_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .InstrData(InstrData), .Branch(Branch),
    .BrTaken(BrTaken), .Halt(Halt),
    .InstrAddr(sat_addr), .TypeBit(sat_tb),
    .OP(sat_op), .RegSel(sat_rs), .Valid(sat_v),
    .Done(sat_d), .CycleCount(sat_cnt)
  );

  typedef struct {
    logic       st;
    logic [8:0] ins;
    logic       br, tk, hl;
    int         addr;
    logic       v, d;
    int         cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic st, logic [8:0] ins,
                              logic br, logic tk, logic hl,
                              int addr, logic v, logic d,
                              int cnt);
    vec_t r;
    r.st = st; r.ins = ins; r.br = br; r.tk = tk; r.hl = hl;
    r.addr = addr; r.v = v; r.d = d; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [8:0] ins,
                       input logic br, input logic tk,
                       input logic hl);
    Start = st; InstrData = ins;
    Branch = br; BrTaken = tk; Halt = hl;
  endtask

  task automatic run_to(input int tgt);
    int g;
    g = 0;
    while (int'(InstrAddr) != tgt && g < 3000) begin
      @(negedge Clk);
      #1;
      g++;
    end
    chk("run_to", int'(InstrAddr), tgt);
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 9'h0B3, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_valid", int'(Valid), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_addr", int'(InstrAddr), 0);
    chk("rst_cnt", int'(CycleCount), 0);
    chk("dec_type0", int'(TypeBit), 0);
    chk("dec_op0", int'(OP), 11);
    chk("dec_reg0", int'(RegSel), 3);
    InstrData = 9'h1FE;
    #1;
    chk("dec_type1", int'(TypeBit), 1);
    chk("dec_op1", int'(OP), 15);
    chk("dec_reg1", int'(RegSel), 14);
    @(negedge Clk);
    #1;
    chk("idle_valid", int'(Valid), 0);

    tv.push_back(mk(1, 9'h0B3, 0, 0, 0,  0, 0, 0,  0));
    tv.push_back(mk(1, 9'h000, 0, 0, 0,  0, 0, 0,  0));
    tv.push_back(mk(0, 9'h000, 1, 1, 1,  0, 0, 0,  0));
    tv.push_back(mk(0, 9'h011, 0, 0, 0,  0, 1, 0,  0));
    tv.push_back(mk(0, 9'h022, 0, 0, 0,  1, 1, 0,  1));
    tv.push_back(mk(0, 9'h033, 0, 0, 0,  2, 1, 0,  2));
    tv.push_back(mk(0, 9'h044, 0, 0, 0,  3, 1, 0,  3));
    tv.push_back(mk(0, 9'h055, 0, 0, 0,  4, 1, 0,  4));
    tv.push_back(mk(0, 9'h0F0, 0, 0, 1,  5, 1, 0,  5));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  5, 0, 1,  6));
    tv.push_back(mk(0, 9'h1FE, 1, 1, 1,  5, 0, 1,  6));
    tv.push_back(mk(1, 9'h000, 0, 0, 0,  5, 0, 1,  6));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  0, 0, 0,  0));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  0, 1, 0,  0));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  1, 1, 0,  1));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  2, 1, 0,  2));
    tv.push_back(mk(0, 9'h1FE, 1, 1, 0,  3, 1, 0,  3));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  1, 1, 0,  4));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  2, 1, 0,  5));
    tv.push_back(mk(0, 9'h1FE, 1, 0, 0,  3, 1, 0,  6));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  4, 1, 0,  7));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  5, 1, 0,  8));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  6, 1, 0,  9));
    tv.push_back(mk(0, 9'h005, 1, 1, 1,  7, 1, 0, 10));
    tv.push_back(mk(0, 9'h000, 0, 0, 0,  7, 0, 1, 11));

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].ins, tv[i].br, tv[i].tk, tv[i].hl);
      #1;
      chk($sformatf("v%0d_addr", i), int'(InstrAddr), tv[i].addr);
      chk($sformatf("v%0d_valid", i), int'(Valid), int'(tv[i].v));
      chk($sformatf("v%0d_done", i), int'(Done), int'(tv[i].d));
      chk($sformatf("v%0d_cnt", i), int'(CycleCount), tv[i].cnt);
      @(negedge Clk);
    end

    // Restart, run to 40, then abort with Start
    drive(1'b1, 9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    #1;
    run_to(40);
    chk("pc40_cnt", int'(CycleCount), 40);
    chk("pc40_valid", int'(Valid), 1);
    chk("sat_cnt", int'(sat_cnt), 7);
    Start = 1'b1;
    @(negedge Clk);
    #1;
    chk("abort_valid", int'(Valid), 0);
    chk("abort_addr", int'(InstrAddr), 0);
    chk("abort_cnt", int'(CycleCount), 0);
    chk("abort_satcnt", int'(sat_cnt), 0);
    Start = 1'b0;
    @(negedge Clk);
    #1;
    chk("resume_valid", int'(Valid), 1);
    chk("resume_addr0", int'(InstrAddr), 0);
    @(negedge Clk);
    #1;
    chk("resume_addr1", int'(InstrAddr), 1);

    // Wrap-around on branch and on increment
    run_to(1020);
    drive(1'b0, 9'h00A, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    #1;
    chk("br_wrap_fwd", int'(InstrAddr), 6);
    drive(1'b0, 9'h0F9, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    #1;
    chk("br_wrap_back", int'(InstrAddr), 1023);
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    chk("inc_wrap", int'(InstrAddr), 0);
    drive(1'b0, 9'h080, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    #1;
    chk("br_m128", int'(InstrAddr), 896);
    drive(1'b0, 9'h100, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    #1;
    chk("br_zero", int'(InstrAddr), 896);
    drive(1'b0, 9'h080, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    chk("br_not_taken", int'(InstrAddr), 897);

    // Reset beats Start
    Reset = 1'b1;
    drive(1'b1, 9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    chk("rs_valid", int'(Valid), 0);
    chk("rs_addr", int'(InstrAddr), 0);
    chk("rs_cnt", int'(CycleCount), 0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    #1;
    chk("rs_idle_valid", int'(Valid), 0);
    @(negedge Clk);
    #1;
    chk("rs_idle_valid2", int'(Valid), 0);
    chk("rs_idle_done", int'(Done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder in the accumulator processor.
- Holds the program counter and drives the instruction-ROM address. Splits the returned 9-bit instruction into the TypeBit, OP and register fields consumed by the decoder.
- Takes the decoder's Branch and Halt strobes back to select the next PC.
- Runs a start/run/halt sequencer and keeps a cycle counter for the testbench.

Parameters:
- PC_W, 10, program-counter and instruction-address width (ROM depth 2^PC_W).
- CNT_W, 16, cycle-counter width.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; high arms the unit, falling level launches the program.
- InstrData  in  9  combinational ROM read data for InstrAddr.
- Branch  in  1  from decoder: current instruction is a branch.
- BrTaken  in  1  from datapath: branch condition true this cycle.
- Halt  in  1  from decoder: current instruction is halt.
- InstrAddr  out  PC_W  equals PC.
- TypeBit  out  1  InstrData[8].
- OP  out  4  InstrData[7:4].
- RegSel  out  4  InstrData[3:0].
- Valid  out  1  high only in RUN; downstream writes must be qualified by it.
- Done  out  1  high in HALTED.
- CycleCount  out  CNT_W  cycles spent in RUN.

Behaviour:
- FSM states: IDLE, ARMED, RUN, HALTED. Registered state; TypeBit/OP/RegSel/InstrAddr are combinational.
- Reset, which has priority over everything:
  - state=IDLE, PC=0, CycleCount=0.
  - Valid=0, Done=0 in the following cycle.
- Start=1 in any state, with Reset=0:
  - Next state is ARMED; PC<=0; CycleCount<=0.
  - Aborts a running program mid-stream.
- ARMED with Start=0: next state RUN; PC stays 0, so the first fetched address is 0.
- IDLE with Start=0: stays IDLE. Branch and Halt are ignored in IDLE, ARMED and HALTED.
- RUN: Valid=1, CycleCount increments each cycle and saturates at all-ones. Next PC, in priority order:
  - Halt=1: PC holds; next state HALTED.
  - Branch=1 and BrTaken=1: PC <= PC + sign_extend(InstrData[7:0]) to PC_W, modulo 2^PC_W.
  - Branch=1 and BrTaken=0: PC <= PC+1.
  - Otherwise: PC <= PC+1, modulo 2^PC_W. 2^PC_W-1 wraps to 0 with no flag.
  - Halt and Branch both high: Halt wins.
- Latency:
  - Single-cycle fetch; InstrAddr is PC with zero delay.
  - A branch target is presented on the cycle after the branch instruction.
  - The halt cycle counts in CycleCount.
- HALTED: Done=1, Valid=0, PC and CycleCount frozen. Exits only via Start or Reset.
- Offset of 0 with branch taken: PC unchanged, an infinite loop by design with no special casing. Offset 0x80 means -128.

Test Plan:
- Reset, then Start high 2 cycles, then low, with ROM of 5 non-branch instructions then halt at address 5:
  - InstrAddr sequence 0,1,2,3,4,5.
  - Done=1 from the cycle after address 5; CycleCount=6; PC holds 5.
- Taken branch at address 3 with InstrData=9'h1_FE (offset -2), BrTaken=1:
  - Next InstrAddr=1.
  - Same instruction with BrTaken=0: next InstrAddr=4.
- Forward branch at PC=1020 (PC_W=10) with offset +10: next InstrAddr=6 (wrap). A non-branch at PC=1023 goes to 0.
- Halt=1 and Branch=1 together at PC=7 with BrTaken=1: PC stays 7 and state goes HALTED.
- Start asserted at PC=40 during RUN:
  - Valid drops next cycle, PC=0, CycleCount=0.
  - After Start falls, fetch resumes at 0.
  - Start and Reset together: state IDLE, not ARMED.
- Decode fields for InstrData=9'h0_B3: TypeBit=0, OP=4'hB, RegSel=4'h3. Valid=0 throughout IDLE and HALTED.
